// File: rtl/shared_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : shared_mem_responder
// Brief    : Two-core shared memory responder. Round-robin arbitration, one
//            fixed-latency transaction at a time, one response per request.
//            Optional macro MEM_SNOOP_INVAL_EN adds a cross-core invalidate
//            strobe on every write.
// Revision : 1.0 - initial release
// ============================================================================
module shared_mem_responder #(
    parameter int AW        = 32,
    parameter int LINE_W    = 32,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 3,
    parameter     INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*AW-1:0]       req_addr,
    input  logic [2*LINE_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            resp_valid,
    output logic [LINE_W-1:0]     resp_rdata
`ifdef MEM_SNOOP_INVAL_EN
    ,
    output logic [1:0]            inval_valid,
    output logic [AW-1:0]         inval_addr
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LINE_W-1:0]   r_mem [DEPTH];

    logic                r_last_grant;
    logic                r_grant;
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_rdata_hold;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_grant;
    logic                w_idle;
    logic                w_accept;
    logic                w_in_resp;
    logic [IDX_W-1:0]    w_idx;
    logic [LINE_W-1:0]   w_resp_data;

    // On a tie the core that was not served last wins; reset leaves core0 first.
    always_comb begin
        w_grant = 1'b0;
        case (req_valid)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
    end

    assign w_idle      = (r_state == S_IDLE) && reset;
    assign w_accept    = w_idle && req_valid[w_grant];
    assign req_ready   = w_accept ? {w_grant, ~w_grant} : 2'b00;
    assign w_in_resp   = (r_state == S_RESP);
    assign w_idx       = r_addr[IDX_W-1:0];
    assign w_resp_data = r_we ? r_wdata : r_mem[w_idx];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_BUSY;
            S_BUSY: if (r_cnt == CNT_W'(1)) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_grant <= w_grant;
                r_we    <= req_we[w_grant];
                r_addr  <= w_grant ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                r_wdata <= w_grant ? req_wdata[2*LINE_W-1:LINE_W] : req_wdata[LINE_W-1:0];
                r_cnt   <= CNT_W'(LATENCY - 1);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_in_resp) begin
                r_last_grant <= r_grant;
                r_rdata_hold <= w_resp_data;
            end
        end
    end

    // Array has no reset; a write lands only on the edge that ends RESP.
    always_ff @(posedge clk) begin
        if (w_in_resp && r_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign resp_valid = w_in_resp ? {r_grant, ~r_grant} : 2'b00;
    assign resp_rdata = w_in_resp ? w_resp_data : r_rdata_hold;

`ifdef MEM_SNOOP_INVAL_EN
    assign inval_valid = (w_in_resp && r_we) ? {~r_grant, r_grant} : 2'b00;
    assign inval_addr  = (w_in_resp && r_we) ? r_addr : '0;
`else
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, r_addr[AW-1:IDX_W]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_mem_responder
// Brief    : Directed scoreboard bench for shared_mem_responder (LATENCY=3
//            main instance plus a LATENCY=1 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_mem_responder;

    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req_valid, req_we, req_ready, resp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*LW-1:0] req_wdata;
    logic [LW-1:0]   resp_rdata;

    logic [1:0]      b_valid, b_we, b_ready, b_resp_valid;
    logic [2*AW-1:0] b_addr;
    logic [2*LW-1:0] b_wdata;
    logic [LW-1:0]   b_rdata;

`ifdef MEM_SNOOP_INVAL_EN
    logic [1:0]      inval_valid, b_inval_valid;
    logic [AW-1:0]   inval_addr, b_inval_addr;
`endif

    shared_mem_responder #(.AW(AW), .LINE_W(LW), .DEPTH(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
`ifdef MEM_SNOOP_INVAL_EN
        , .inval_valid(inval_valid), .inval_addr(inval_addr)
`endif
    );

    shared_mem_responder #(.AW(AW), .LINE_W(LW), .DEPTH(256), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .resp_valid(b_resp_valid), .resp_rdata(b_rdata)
`ifdef MEM_SNOOP_INVAL_EN
        , .inval_valid(b_inval_valid), .inval_addr(b_inval_addr)
`endif
    );

    typedef struct {
        int             core;
        logic           we;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  data;
        int             cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [LW-1:0] last_data = '0;
    int            acc, st;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every strobe must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset) begin
            if (resp_valid !== 2'b00) begin
                if (sb.size() == 0) begin
                    check("spurious_resp", resp_valid, 2'b00);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_valid", resp_valid, (mon_e.core == 1) ? 2'b10 : 2'b01);
                    check("resp_rdata", resp_rdata, mon_e.data);
                    check("resp_cycle", cyc, mon_e.cyc);
                    last_data = mon_e.data;
`ifdef MEM_SNOOP_INVAL_EN
                    check("inval_valid", inval_valid,
                          mon_e.we ? ((mon_e.core == 1) ? 2'b01 : 2'b10) : 2'b00);
                    check("inval_addr", inval_addr, mon_e.we ? mon_e.addr : '0);
`endif
                end
            end else begin
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    check("resp_missing_at_cycle", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
`ifdef MEM_SNOOP_INVAL_EN
                check("inval_idle", inval_valid, 2'b00);
`endif
            end
        end
    end

    task automatic issue(input int c, input logic we, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wd, input logic [LW-1:0] expd, input bit push,
                         output int acc_cyc, output int start_cyc);
        bit got;
        got     = 1'b0;
        acc_cyc = -1;
        @(negedge clk);
        start_cyc = cyc;
        req_valid[c]          = 1'b1;
        req_we[c]             = we;
        req_addr[c*AW +: AW]  = addr;
        req_wdata[c*LW +: LW] = wd;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (req_ready[c] === 1'b1) begin
                got     = 1'b1;
                acc_cyc = cyc;
                check("ready_onehot", req_ready, (c == 1) ? 2'b10 : 2'b01);
                if (push) sb.push_back('{c, we, addr, expd, cyc + LAT});
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
        req_valid[c] = 1'b0;
        #1;
        check("ready_low_busy", req_ready, 2'b00);
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && sb.size() > 0; n++) @(negedge clk);
        check("drain_outstanding", sb.size(), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rdata_hold", resp_rdata, last_data);
    endtask

    task automatic both_read(input logic [AW-1:0] a, input logic [LW-1:0] d);
        int a0;
        bit got;
        @(negedge clk);
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {a, a};
        #1;
        check("tie_grant", req_ready, 2'b01);
        a0 = cyc;
        sb.push_back('{0, 1'b0, a, d, a0 + LAT});
        @(negedge clk);
        req_valid[0] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            #1;
            if (req_ready[1] === 1'b1) begin
                got = 1'b1;
                check("core1_accept_cycle", cyc, a0 + LAT + 1);
                sb.push_back('{1, 1'b0, a, d, cyc + LAT});
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("core1_timeout", 1'b0, 1'b1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0;
        b_valid = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_resp_rdata", resp_rdata, 32'h0);
`ifdef MEM_SNOOP_INVAL_EN
        check("rst_inval_valid", inval_valid, 2'b00);
        check("rst_inval_addr", inval_addr, 32'h0);
`endif
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, acc, st);
        check("t1_ready_same_cycle", acc, st);
        drain();
        issue(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, acc, st);
        drain();
        // Upper address bits alias onto the same word.
        issue(0, 1'b0, 32'h110, 32'h0, 32'hDEADBEEF, 1'b1, acc, st);
        drain();

        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        both_read(32'h10, 32'hDEADBEEF);
        both_read(32'h10, 32'hDEADBEEF);

        issue(0, 1'b1, 32'h20, 32'h11, 32'h11, 1'b1, acc, st);
        drain();
        issue(1, 1'b1, 32'h20, 32'h22, 32'h22, 1'b0, acc, st);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("midrst_resp_valid", resp_valid, 2'b00);
            check("midrst_resp_rdata", resp_rdata, 32'h0);
            @(negedge clk);
        end
        reset = 1'b1;
        issue(0, 1'b0, 32'h20, 32'h0, 32'h11, 1'b1, acc, st);
        drain();

        issue(0, 1'b1, 32'h30, 32'h5A5A0030, 32'h5A5A0030, 1'b1, acc, st);
        drain();
        issue(0, 1'b0, 32'h30, 32'h0, 32'h5A5A0030, 1'b1, acc, st);
        drain();

        @(negedge clk);
        b_valid = 2'b01; b_we = 2'b01;
        b_addr[AW-1:0] = 32'h5; b_wdata[LW-1:0] = 32'hA5A5A5A5;
        #1;
        check("l1_wr_ready", b_ready, 2'b01);
        @(negedge clk);
        check("l1_wr_resp", b_resp_valid, 2'b01);
        b_we = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("l1_rd_ready", b_ready, 2'b01);
            check("l1_rd_no_resp_yet", b_resp_valid, 2'b00);
            @(negedge clk);
            check("l1_rd_resp", b_resp_valid, 2'b01);
            check("l1_rd_data", b_rdata, 32'hA5A5A5A5);
            check("l1_ready_low_in_resp", b_ready, 2'b00);
        end
        b_valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
